// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types for the memory stage.
//  word_t      32-bit datapath word
//  regbits_t   5-bit register index
//  memstate_t  memory-stage FSM state {IDLE, WAIT}
//  memwb_t     MEM/WB pipeline register contents
//  lui_word()  forms the LUI writeback word from an instruction
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } memstate_t;

    localparam int LUI_SHIFT = 16;

    typedef struct packed {
        logic     wen;
        regbits_t wsel;
        word_t    wdat;
        word_t    instr;
    } memwb_t;

    // Immediate sits in instr[15:0]; shifting left drops the opcode bits.
    function automatic word_t lui_word(input word_t instr);
        return word_t'(instr << LUI_SHIFT);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the memory stage and dmem.
//  dmemREN/dmemWEN   read/write request (master -> slave)
//  dmemaddr          access address    (master -> slave)
//  dmemstore         store data        (master -> slave)
//  dhit              access complete   (slave -> master)
//  dmemload          load data, valid with dhit (slave -> master)
interface mem_stage_if;
    import cpu_types_pkg::*;

    logic  dmemREN;
    logic  dmemWEN;
    word_t dmemaddr;
    word_t dmemstore;
    logic  dhit;
    word_t dmemload;

    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore,
        input  dhit, dmemload
    );

    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore,
        output dhit, dmemload
    );
endinterface

// File: rtl/memwb_latch.sv
// MEM/WB pipeline register.
//  CLK     clock
//  nRST    synchronous active-low reset (clears to all-zero)
//  bubble  load an all-zero (no-op) entry instead of d
//  d       next MEM/WB contents
//  q       registered MEM/WB contents
module memwb_latch
    import cpu_types_pkg::*;
(
    input  logic   CLK,
    input  logic   nRST,
    input  logic   bubble,
    input  memwb_t d,
    output memwb_t q
);

    // NOTE: non-blocking assignment for every clocked register so all
    // flops sample pre-edge values regardless of process ordering.
    always_ff @(posedge CLK) begin
        if (!nRST || bubble) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage plus MEM/WB register.
// Issues the dmem request from the EX/MEM outputs, stalls upstream until dhit,
// forms the writeback word (ALU / load / LUI) and keeps a sticky halt.
// Optional feature macro: MEM_WATCHDOG_EN (dmem timeout -> memErr + halt).
// Ports:
//  CLK, nRST            clock, synchronous active-low reset
//  memcuDRE/DWE/HALT    load / store / halt in MEM
//  memMemToReg, memWEN, memLUIflag, memwsel, memOutput_Port, memrdat2, meminstr
//                       EX/MEM register outputs
//  dbus                 dmem bus (master side)
//  memStall             hold PC/IF/ID/EX/MEM this cycle
//  wbWEN, wbwsel, wbwdat, wbinstr   MEM/WB register outputs
//  halt                 sticky halt
//  memErr               sticky dmem timeout fault (0 without MEM_WATCHDOG_EN)
module mem_stage
    import cpu_types_pkg::*;
#(
    parameter int WDOG_CYCLES = 255
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               memcuDRE,
    input  logic               memcuDWE,
    input  logic               memcuHALT,
    input  logic               memMemToReg,
    input  logic               memWEN,
    input  logic               memLUIflag,
    input  regbits_t           memwsel,
    input  word_t              memOutput_Port,
    input  word_t              memrdat2,
    input  word_t              meminstr,
    mem_stage_if.master        dbus,
    output logic               memStall,
    output logic               wbWEN,
    output regbits_t           wbwsel,
    output word_t              wbwdat,
    output word_t              wbinstr,
    output logic               halt,
    output logic               memErr
);

    memstate_t state, state_next;
    logic      acc;
    logic      fault;
    memwb_t    wb_d, wb_q;

    // Requests are masked by halt so a halted CPU never touches memory.
    assign acc            = (memcuDRE | memcuDWE) & ~halt;
    assign dbus.dmemREN   = memcuDRE & ~halt;
    assign dbus.dmemWEN   = memcuDWE & ~halt;
    assign dbus.dmemaddr  = memOutput_Port;
    assign dbus.dmemstore = memrdat2;
    assign memStall       = acc & ~dbus.dhit;

`ifdef MEM_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    logic [WDOG_W-1:0] wdog;

    // dhit on the expiry cycle wins: fault only when still missing.
    assign fault = (state == WAIT) && !dbus.dhit && (wdog == WDOG_W'(WDOG_CYCLES));

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wdog <= '0;
        end else if (state == WAIT && !dbus.dhit) begin
            wdog <= wdog + 1'b1;
        end else begin
            wdog <= '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            memErr <= 1'b0;
        end else if (fault) begin
            memErr <= 1'b1;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^WDOG_CYCLES;
    assign fault      = 1'b0;
    assign memErr     = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: next-state defaults to the current state before the case so no
    // path leaves state_next unassigned (which would infer a latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (acc && !dbus.dhit) state_next = WAIT;
            WAIT: if (dbus.dhit || fault) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Halt is only taken when the halting instruction actually leaves MEM.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            halt <= 1'b0;
        end else if ((memcuHALT && !memStall) || fault) begin
            halt <= 1'b1;
        end
    end

    // LUI has priority over MemToReg.
    always_comb begin
        wb_d.wen   = memWEN & ~halt;
        wb_d.wsel  = memwsel;
        wb_d.instr = meminstr;
        if (memLUIflag) begin
            wb_d.wdat = lui_word(meminstr);
        end else if (memMemToReg) begin
            wb_d.wdat = dbus.dmemload;
        end else begin
            wb_d.wdat = memOutput_Port;
        end
    end

    // A fault cycle is always a stall cycle, so memStall alone covers the bubble.
    memwb_latch u_memwb (
        .CLK    (CLK),
        .nRST   (nRST),
        .bubble (memStall),
        .d      (wb_d),
        .q      (wb_q)
    );

    assign wbWEN   = wb_q.wen;
    assign wbwsel  = wb_q.wsel;
    assign wbwdat  = wb_q.wdat;
    assign wbinstr = wb_q.instr;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage. Expected MEM/WB contents are pushed to a
// scoreboard queue when a cycle's stimulus is driven and popped after the edge.
// Watchdog scenario is compiled only with MEM_WATCHDOG_EN.
module tb_mem_stage;
    import cpu_types_pkg::*;

    logic     CLK = 1'b0;
    logic     nRST;
    logic     memcuDRE, memcuDWE, memcuHALT, memMemToReg, memWEN, memLUIflag;
    regbits_t memwsel;
    word_t    memOutput_Port, memrdat2, meminstr;
    logic     memStall, wbWEN, halt, memErr;
    regbits_t wbwsel;
    word_t    wbwdat, wbinstr;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        wen;
        logic [4:0]  wsel;
        logic [31:0] wdat;
        logic [31:0] instr;
    } wb_exp_t;

    wb_exp_t sb[$];

    mem_stage_if dbus ();

    mem_stage #(.WDOG_CYCLES(4)) dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .memcuDRE       (memcuDRE),
        .memcuDWE       (memcuDWE),
        .memcuHALT      (memcuHALT),
        .memMemToReg    (memMemToReg),
        .memWEN         (memWEN),
        .memLUIflag     (memLUIflag),
        .memwsel        (memwsel),
        .memOutput_Port (memOutput_Port),
        .memrdat2       (memrdat2),
        .meminstr       (meminstr),
        .dbus           (dbus),
        .memStall       (memStall),
        .wbWEN          (wbWEN),
        .wbwsel         (wbwsel),
        .wbwdat         (wbwdat),
        .wbinstr        (wbinstr),
        .halt           (halt),
        .memErr         (memErr)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        memcuDRE = 0; memcuDWE = 0; memcuHALT = 0; memMemToReg = 0;
        memWEN = 0; memLUIflag = 0; memwsel = '0;
        memOutput_Port = '0; memrdat2 = '0; meminstr = '0;
        dbus.dhit = 0; dbus.dmemload = '0;
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step(input string tag, input logic x_stall, input logic x_ren,
                        input logic x_wen, input logic e_wen, input logic [4:0] e_wsel,
                        input logic [31:0] e_wdat, input logic [31:0] e_instr,
                        input logic x_halt);
        wb_exp_t e;
        #1;
        check({tag, ".stall"}, 32'(memStall), 32'(x_stall));
        check({tag, ".ren"},   32'(dbus.dmemREN), 32'(x_ren));
        check({tag, ".wen_req"}, 32'(dbus.dmemWEN), 32'(x_wen));
        check({tag, ".addr"},  dbus.dmemaddr, memOutput_Port);
        check({tag, ".store"}, dbus.dmemstore, memrdat2);
        e.wen = e_wen; e.wsel = e_wsel; e.wdat = e_wdat; e.instr = e_instr;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, ".wbWEN"},   32'(wbWEN), 32'(e.wen));
            check({tag, ".wbwsel"},  32'(wbwsel), 32'(e.wsel));
            check({tag, ".wbwdat"},  wbwdat, e.wdat);
            check({tag, ".wbinstr"}, wbinstr, e.instr);
        end
        check({tag, ".halt"},   32'(halt), 32'(x_halt));
        check({tag, ".memErr"}, 32'(memErr), 32'd0);
        @(negedge CLK);
    endtask

    initial begin
        clear_inputs();
        nRST = 0;
        @(negedge CLK);
        @(negedge CLK);
        #1;
        check("rst.wbWEN",   32'(wbWEN), 32'd0);
        check("rst.wbwsel",  32'(wbwsel), 32'd0);
        check("rst.wbwdat",  wbwdat, 32'd0);
        check("rst.wbinstr", wbinstr, 32'd0);
        check("rst.halt",    32'(halt), 32'd0);
        check("rst.memErr",  32'(memErr), 32'd0);
        check("rst.stall",   32'(memStall), 32'd0);
        @(negedge CLK);
        nRST = 1;

        // 1: ALU op, no memory access
        memWEN = 1; memwsel = 5'd8; memOutput_Port = 32'h1234; meminstr = 32'h0123_4567;
        step("alu", 0, 0, 0, 1, 5'd8, 32'h1234, 32'h0123_4567, 0);

        // 2: load, dhit on the third cycle
        clear_inputs();
        memcuDRE = 1; memMemToReg = 1; memWEN = 1; memwsel = 5'd9;
        memOutput_Port = 32'h100; meminstr = 32'h8C09_0100; dbus.dmemload = 32'hCAFEF00D;
        step("ld.w1", 1, 1, 0, 0, 5'd0, 32'd0, 32'd0, 0);
        step("ld.w2", 1, 1, 0, 0, 5'd0, 32'd0, 32'd0, 0);
        dbus.dhit = 1;
        step("ld.hit", 0, 1, 0, 1, 5'd9, 32'hCAFEF00D, 32'h8C09_0100, 0);

        // 3: zero-wait store
        clear_inputs();
        memcuDWE = 1; dbus.dhit = 1; memrdat2 = 32'hDEAD; memOutput_Port = 32'h200;
        memwsel = 5'd3; meminstr = 32'hAC03_0200;
        step("st", 0, 0, 1, 0, 5'd3, 32'h200, 32'hAC03_0200, 0);
        // FSM must be IDLE: next access with immediate hit also completes without stall
        clear_inputs();
        memcuDRE = 1; dbus.dhit = 1; memMemToReg = 1; memWEN = 1; memwsel = 5'd5;
        memOutput_Port = 32'h204; meminstr = 32'h8C05_0204; dbus.dmemload = 32'h1357_9BDF;
        step("ld0", 0, 1, 0, 1, 5'd5, 32'h1357_9BDF, 32'h8C05_0204, 0);

        // 4: LUI beats MemToReg
        clear_inputs();
        memLUIflag = 1; memMemToReg = 1; memWEN = 1; memwsel = 5'd4;
        meminstr = 32'h3C04_ABCD; memOutput_Port = 32'h5555; dbus.dmemload = 32'h1111;
        step("lui", 0, 0, 0, 1, 5'd4, 32'hABCD_0000, 32'h3C04_ABCD, 0);

        // 5: reset in the middle of a wait, then an immediate-hit load
        clear_inputs();
        memcuDRE = 1; memWEN = 1; memwsel = 5'd6; memOutput_Port = 32'h300;
        meminstr = 32'h8C06_0300;
        step("rw.w1", 1, 1, 0, 0, 5'd0, 32'd0, 32'd0, 0);
        step("rw.w2", 1, 1, 0, 0, 5'd0, 32'd0, 32'd0, 0);
        nRST = 0;
        step("rw.rst", 1, 1, 0, 0, 5'd0, 32'd0, 32'd0, 0);
        nRST = 1;
        clear_inputs();
        memcuDRE = 1; dbus.dhit = 1; memMemToReg = 1; memWEN = 1; memwsel = 5'd7;
        memOutput_Port = 32'h304; meminstr = 32'h8C07_0304; dbus.dmemload = 32'h2468_ACE0;
        step("rw.ld", 0, 1, 0, 1, 5'd7, 32'h2468_ACE0, 32'h8C07_0304, 0);

        // 6: halt is sticky and blocks later requests
        clear_inputs();
        memcuHALT = 1; memWEN = 1; memwsel = 5'd2; memOutput_Port = 32'h77;
        meminstr = 32'hFFFF_FFFF;
        step("hlt", 0, 0, 0, 1, 5'd2, 32'h77, 32'hFFFF_FFFF, 1);
        clear_inputs();
        memcuDRE = 1; memWEN = 1; memwsel = 5'd10; memOutput_Port = 32'h400;
        meminstr = 32'h8C0A_0400;
        step("hlt.ld", 0, 0, 0, 0, 5'd10, 32'h400, 32'h8C0A_0400, 1);
        nRST = 0;
        step("hlt.rst", 0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 0);
        nRST = 1;

`ifdef MEM_WATCHDOG_EN
        // 7: watchdog expiry on a load that never hits
        begin
            int waited;
            bit seen;
            clear_inputs();
            memcuDRE = 1; memWEN = 1; memwsel = 5'd11; memOutput_Port = 32'h500;
            meminstr = 32'h8C0B_0500;
            waited = 0;
            seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(posedge CLK);
                #1;
                waited++;
                if (memErr) seen = 1;
            end
            check("wd.seen",   32'(seen), 32'd1);
            check("wd.halt",   32'(halt), 32'd1);
            check("wd.wbWEN",  32'(wbWEN), 32'd0);
            check("wd.ren",    32'(dbus.dmemREN), 32'd0);
            check("wd.stall",  32'(memStall), 32'd0);
            @(negedge CLK);
            nRST = 0;
            @(posedge CLK);
            #1;
            check("wd.rst.memErr", 32'(memErr), 32'd0);
            check("wd.rst.halt",   32'(halt), 32'd0);
            @(negedge CLK);
            nRST = 1;
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
